// File: rtl/m68k_region_decoder.sv
// 68000 bus region decoder: programmable base/mask windows drive a registered one-hot
// chip select, with a DTACK watchdog that raises BERR_L on unmapped or timed-out cycles.
module m68k_region_decoder #(
    parameter int ADDR_W      = 32,
    parameter int NUM_REGIONS = 8,
    parameter int TIMEOUT     = 255,
    parameter int CNT_W       = 8,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] RST_BASE = {
        32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
        32'h0800_0000, 32'h0040_0000, 32'hF000_0000, 32'h0000_0000},
    parameter logic [NUM_REGIONS*ADDR_W-1:0] RST_MASK = {
        32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
        32'hFC00_0000, 32'hFFFF_0000, 32'hFFFC_0000, 32'hFFFF_8000},
    parameter logic [NUM_REGIONS-1:0] RST_EN = 8'b0000_1111,
    localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
    input  logic                   Clk,
    input  logic                   Reset_L,
    input  logic [ADDR_W-1:0]      Address,
    input  logic                   AS_L,
    input  logic                   DtackIn_L,
    input  logic                   CfgWe,
    input  logic [IDX_W-1:0]       CfgIndex,
    input  logic [ADDR_W-1:0]      CfgBase,
    input  logic [ADDR_W-1:0]      CfgMask,
    input  logic                   CfgEnable,
    output logic [NUM_REGIONS-1:0] Select_H,
    output logic                   BERR_L,
    output logic                   BerrCause,
    output logic [ADDR_W-1:0]      BerrAddr
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StActive = 2'd1,
        StDone   = 2'd2,
        StFault  = 2'd3
    } busState_t;

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

    // Isolates the lowest set bit so overlapping windows resolve to the lower index.
    function automatic logic [NUM_REGIONS-1:0] lowestOneHot(input logic [NUM_REGIONS-1:0] v);
        lowestOneHot = v & (~v + {{(NUM_REGIONS-1){1'b0}}, 1'b1});
    endfunction

    logic [ADDR_W-1:0]      baseTab [NUM_REGIONS];
    logic [ADDR_W-1:0]      maskTab [NUM_REGIONS];
    logic [NUM_REGIONS-1:0] enTab;

    busState_t              state, stateNext;
    logic [NUM_REGIONS-1:0] selectReg, selectNext;
    logic                   berrReg, berrNext;
    logic                   causeReg, causeNext;
    logic [ADDR_W-1:0]      berrAddrReg, berrAddrNext;
    logic [ADDR_W-1:0]      latchAddr, latchNext;
    logic [CNT_W-1:0]       cnt, cntNext, cntInc;
    logic [NUM_REGIONS-1:0] hitVec;
    logic [NUM_REGIONS-1:0] winner;

    // Region table: loads reset windows, then takes single-entry config writes.
    always_ff @(posedge Clk or negedge Reset_L) begin
        if (!Reset_L) begin
            for (int i = 0; i < NUM_REGIONS; i++) begin
                baseTab[i] <= RST_BASE[i*ADDR_W +: ADDR_W];
                maskTab[i] <= RST_MASK[i*ADDR_W +: ADDR_W];
                enTab[i]   <= RST_EN[i];
            end
        end else begin
            // Indices with no matching entry never compare equal, so they are dropped.
            for (int i = 0; i < NUM_REGIONS; i++) begin
                if (CfgWe && (CfgIndex == IDX_W'(i))) begin
                    baseTab[i] <= CfgBase;
                    maskTab[i] <= CfgMask;
                    enTab[i]   <= CfgEnable;
                end
            end
        end
    end

    // Window compare for every region against the live address.
    always_comb begin
        hitVec = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            hitVec[i] = enTab[i] & ((Address & maskTab[i]) == (baseTab[i] & maskTab[i]));
        end
    end

    assign winner = lowestOneHot(hitVec);
    assign cntInc = cnt + CNT_W'(1);

    // Bus-cycle supervisor: next state and next registered outputs.
    always_comb begin
        stateNext    = state;
        selectNext   = selectReg;
        berrNext     = berrReg;
        causeNext    = causeReg;
        berrAddrNext = berrAddrReg;
        latchNext    = latchAddr;
        cntNext      = cnt;
        case (state)
            StIdle: begin
                if (!AS_L) begin
                    if (|hitVec) begin
                        selectNext = winner;
                        cntNext    = '0;
                        latchNext  = Address;
                        stateNext  = StActive;
                    end else begin
                        berrNext     = 1'b0;
                        causeNext    = 1'b0;
                        berrAddrNext = Address;
                        stateNext    = StFault;
                    end
                end else begin
                    stateNext = StIdle;
                end
            end
            StActive: begin
                // Strobe release beats a coincident DTACK; DTACK beats the final watchdog tick.
                if (AS_L) begin
                    selectNext = '0;
                    stateNext  = StIdle;
                end else if (!DtackIn_L) begin
                    stateNext = StDone;
                end else begin
                    cntNext = cntInc;
                    if (cntInc == TIMEOUT_LAST) begin
                        selectNext   = '0;
                        berrNext     = 1'b0;
                        causeNext    = 1'b1;
                        berrAddrNext = latchAddr;
                        stateNext    = StFault;
                    end else begin
                        stateNext = StActive;
                    end
                end
            end
            StDone: begin
                if (AS_L) begin
                    selectNext = '0;
                    stateNext  = StIdle;
                end else begin
                    stateNext = StDone;
                end
            end
            StFault: begin
                if (AS_L) begin
                    berrNext  = 1'b1;
                    stateNext = StIdle;
                end else begin
                    stateNext = StFault;
                end
            end
            default: begin
                selectNext = '0;
                berrNext   = 1'b1;
                stateNext  = StIdle;
            end
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge Clk or negedge Reset_L) begin
        if (!Reset_L) begin
            state       <= StIdle;
            selectReg   <= '0;
            berrReg     <= 1'b1;
            causeReg    <= 1'b0;
            berrAddrReg <= '0;
            latchAddr   <= '0;
            cnt         <= '0;
        end else begin
            state       <= stateNext;
            selectReg   <= selectNext;
            berrReg     <= berrNext;
            causeReg    <= causeNext;
            berrAddrReg <= berrAddrNext;
            latchAddr   <= latchNext;
            cnt         <= cntNext;
        end
    end

    assign Select_H  = selectReg;
    assign BERR_L    = berrReg;
    assign BerrCause = causeReg;
    assign BerrAddr  = berrAddrReg;

endmodule

// File: tb/tb_m68k_region_decoder.sv
// Scoreboard bench for m68k_region_decoder: each driven cycle queues the expected
// outputs, which are popped and compared just after the clock edge that produces them.
module tb_m68k_region_decoder;

    localparam int TIMEOUT = 255;

    logic        Clk;
    logic        Reset_L;
    logic [31:0] Address;
    logic        AS_L;
    logic        DtackIn_L;
    logic        CfgWe;
    logic [2:0]  CfgIndex;
    logic [31:0] CfgBase;
    logic [31:0] CfgMask;
    logic        CfgEnable;
    logic [7:0]  Select_H;
    logic        BERR_L;
    logic        BerrCause;
    logic [31:0] BerrAddr;

    typedef struct {
        logic [7:0]  sel;
        logic        berrL;
        logic        cause;
        logic [31:0] addr;
    } exp_t;

    exp_t  expQ[$];
    string tagQ[$];
    int    numChecks = 0;
    int    numPassed = 0;
    logic        lastCause = 1'b0;
    logic [31:0] lastAddr  = 32'h0000_0000;

    m68k_region_decoder dut (
        .Clk       (Clk),
        .Reset_L   (Reset_L),
        .Address   (Address),
        .AS_L      (AS_L),
        .DtackIn_L (DtackIn_L),
        .CfgWe     (CfgWe),
        .CfgIndex  (CfgIndex),
        .CfgBase   (CfgBase),
        .CfgMask   (CfgMask),
        .CfgEnable (CfgEnable),
        .Select_H  (Select_H),
        .BERR_L    (BERR_L),
        .BerrCause (BerrCause),
        .BerrAddr  (BerrAddr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        numChecks++;
        if (obs === exp) numPassed++;
        else $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic checkOutputs(input string tag, input exp_t e);
        checkVal({tag, ".sel"},   {24'h0, Select_H}, {24'h0, e.sel});
        checkVal({tag, ".berr"},  {31'h0, BERR_L},   {31'h0, e.berrL});
        checkVal({tag, ".cause"}, {31'h0, BerrCause}, {31'h0, e.cause});
        checkVal({tag, ".addr"},  BerrAddr,           e.addr);
    endtask

    task automatic stepExpect(input string tag, input logic [7:0] sel, input logic berrL,
                              input logic cause, input logic [31:0] addr);
        exp_t e;
        exp_t got;
        string t;
        e.sel = sel; e.berrL = berrL; e.cause = cause; e.addr = addr;
        expQ.push_back(e);
        tagQ.push_back(tag);
        @(posedge Clk);
        #1;
        got = expQ.pop_front();
        t   = tagQ.pop_front();
        checkOutputs(t, got);
    endtask

    task automatic stepOk(input string tag, input logic [7:0] sel);
        stepExpect(tag, sel, 1'b1, lastCause, lastAddr);
    endtask

    task automatic stepBerr(input string tag, input logic cause, input logic [31:0] addr);
        lastCause = cause;
        lastAddr  = addr;
        stepExpect(tag, 8'h00, 1'b0, cause, addr);
    endtask

    task automatic cfgWrite(input logic [2:0] idx, input logic [31:0] base,
                            input logic [31:0] mask, input logic en);
        CfgWe = 1'b1; CfgIndex = idx; CfgBase = base; CfgMask = mask; CfgEnable = en;
    endtask

    task automatic checkResetState(input string tag);
        exp_t e;
        e.sel = 8'h00; e.berrL = 1'b1; e.cause = 1'b0; e.addr = 32'h0000_0000;
        checkOutputs(tag, e);
    endtask

    initial begin
        Reset_L = 1'b0; Address = 32'h0; AS_L = 1'b1; DtackIn_L = 1'b1;
        CfgWe = 1'b0; CfgIndex = 3'd0; CfgBase = 32'h0; CfgMask = 32'h0; CfgEnable = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        checkResetState("reset");
        Reset_L = 1'b1;

        // Basic ROM cycle completed by DTACK
        Address = 32'h0000_1000; AS_L = 1'b0;
        stepOk("t1.sel", 8'h01);
        stepOk("t1.wait1", 8'h01);
        stepOk("t1.wait2", 8'h01);
        DtackIn_L = 1'b0;
        stepOk("t1.dtack", 8'h01);
        DtackIn_L = 1'b1;
        stepOk("t1.doneHold", 8'h01);
        AS_L = 1'b1; DtackIn_L = 1'b0;
        stepOk("t1.release", 8'h00);
        stepOk("t1.idleDtack", 8'h00);
        DtackIn_L = 1'b1;

        // Other default windows, including strobe-vs-DTACK priority
        Address = 32'h0900_0000; AS_L = 1'b0;
        stepOk("t2.r3", 8'h08);
        AS_L = 1'b1;
        stepOk("t2.r3abort", 8'h00);
        Address = 32'h0040_0010; AS_L = 1'b0;
        stepOk("t2.r2", 8'h04);
        AS_L = 1'b1; DtackIn_L = 1'b0;
        stepOk("t2.asBeatsDtack", 8'h00);
        DtackIn_L = 1'b1;
        Address = 32'hF003_FFFE; AS_L = 1'b0;
        stepOk("t2.r1", 8'h02);
        AS_L = 1'b1;
        stepOk("t2.r1abort", 8'h00);

        // Unmapped access
        Address = 32'h2000_0000; AS_L = 1'b0;
        stepBerr("t3.unmapped", 1'b0, 32'h2000_0000);
        DtackIn_L = 1'b0;
        stepBerr("t3.faultHold", 1'b0, 32'h2000_0000);
        DtackIn_L = 1'b1; AS_L = 1'b1;
        stepOk("t3.release", 8'h00);

        // Watchdog timeout; the address changes after the decode
        Address = 32'h0040_0000; AS_L = 1'b0;
        stepOk("t4.start", 8'h04);
        Address = 32'h2000_0000;
        for (int k = 1; k <= TIMEOUT - 2; k++) stepOk("t4.wait", 8'h04);
        stepBerr("t4.timeout", 1'b1, 32'h0040_0000);
        AS_L = 1'b1;
        stepOk("t4.release", 8'h00);

        // DTACK on the last watchdog cycle rescues the access
        Address = 32'h0040_0000; AS_L = 1'b0;
        stepOk("t4b.start", 8'h04);
        for (int k = 1; k <= TIMEOUT - 2; k++) stepOk("t4b.wait", 8'h04);
        DtackIn_L = 1'b0;
        stepOk("t4b.lastDtack", 8'h04);
        DtackIn_L = 1'b1;
        stepOk("t4b.doneHold", 8'h04);
        AS_L = 1'b1;
        stepOk("t4b.release", 8'h00);

        // Config write coinciding with a decode uses the old entry
        cfgWrite(3'd4, 32'h0C00_0000, 32'hFF00_0000, 1'b1);
        Address = 32'h0C12_3456; AS_L = 1'b0;
        stepBerr("t5.oldEntry", 1'b0, 32'h0C12_3456);
        CfgWe = 1'b0; AS_L = 1'b1;
        stepOk("t5.release", 8'h00);
        AS_L = 1'b0;
        stepOk("t5.r4", 8'h10);
        cfgWrite(3'd4, 32'h0C00_0000, 32'hFF00_0000, 1'b0);
        stepOk("t5.inProgress", 8'h10);
        CfgWe = 1'b0; AS_L = 1'b1;
        stepOk("t5.r4release", 8'h00);
        AS_L = 1'b0;
        stepBerr("t5.r4disabled", 1'b0, 32'h0C12_3456);
        AS_L = 1'b1;
        cfgWrite(3'd4, 32'h0C00_0000, 32'hFF00_0000, 1'b1);
        stepOk("t5.reenable", 8'h00);
        cfgWrite(3'd5, 32'h0000_0000, 32'hFFFF_8000, 1'b1);
        stepOk("t5.progR5", 8'h00);
        CfgWe = 1'b0;
        Address = 32'h0000_1000; AS_L = 1'b0;
        stepOk("t5.overlap", 8'h01);
        AS_L = 1'b1;
        cfgWrite(3'd0, 32'h0000_0000, 32'hFFFF_8000, 1'b0);
        stepOk("t5.disR0", 8'h00);
        CfgWe = 1'b0; AS_L = 1'b0;
        stepOk("t5.r5wins", 8'h20);
        AS_L = 1'b1;
        stepOk("t5.r5release", 8'h00);

        // Asynchronous reset during ACTIVE and during FAULT
        Address = 32'h0C12_3456; AS_L = 1'b0;
        stepOk("t6.active", 8'h10);
        #2 Reset_L = 1'b0;
        #1 checkResetState("t6.rstActive");
        Reset_L = 1'b1;
        lastCause = 1'b0; lastAddr = 32'h0000_0000;
        stepBerr("t6.r4Lost", 1'b0, 32'h0C12_3456);
        #2 Reset_L = 1'b0;
        #1 checkResetState("t6.rstFault");
        Reset_L = 1'b1;
        lastCause = 1'b0; lastAddr = 32'h0000_0000;
        AS_L = 1'b1;
        stepOk("t6.idle", 8'h00);

        $display("%0d/%0d checks passed", numPassed, numChecks);
        $finish;
    end

endmodule
